// File: rtl/mips_iter_divider.sv
// Multi-cycle restoring divider for the MIPS datapath: one quotient bit per clock,
// signed/unsigned modes, divide-by-zero reporting.
// Ports: clk, reset (async, active-high), start, signed_op, dividend, divisor in;
//        busy, done, quotient, remainder, div_by_zero out.
module mips_iter_divider #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic             sgn, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   shifted, diff;
   logic             qbit;
   logic [WIDTH-1:0] rem_n, dvd_n;

   always_comb begin
      sgn   = SIGNED_EN & signed_op;
      a_neg = sgn & dividend[WIDTH-1];
      b_neg = sgn & divisor[WIDTH-1];
      a_mag = a_neg ? -dividend : dividend;
      b_mag = b_neg ? -divisor : divisor;

      // Partial remainder stays below the divisor, so the borrow bit of the
      // WIDTH+1-bit trial subtraction is a reliable sign.
      shifted = {rem_q, dvd_q[WIDTH-1]};
      diff    = shifted - {1'b0, dsr_q};
      qbit    = ~diff[WIDTH];
      rem_n   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      dvd_n   = {dvd_q[WIDTH-2:0], qbit};

      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      dvd_d       = dvd_q;
      dsr_d       = dsr_q;
      neg_q_d     = neg_q_q;
      neg_r_d     = neg_r_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      unique case (state_q)
         S_RUN: begin
            rem_d = rem_n;
            dvd_d = dvd_n;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d     = S_DONE;
               quotient_d  = neg_q_q ? -dvd_n : dvd_n;
               remainder_d = neg_r_q ? -rem_n : rem_n;
               dbz_d       = 1'b0;
            end
         end
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               if (divisor == '0) begin
                  state_d     = S_DONE;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  rem_d   = '0;
                  dvd_d   = a_mag;
                  dsr_d   = b_mag;
                  neg_q_d = a_neg ^ b_neg;
                  neg_r_d = a_neg;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         dvd_q       <= '0;
         dsr_q       <= '0;
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         dvd_q       <= dvd_d;
         dsr_q       <= dsr_d;
         neg_q_q     <= neg_q_d;
         neg_r_q     <= neg_r_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule
